// File: rtl/bitwise_pkg.sv
// ---------------------------------------------------------------------------
// bitwise_pkg
//
// Shared definitions for the bitwise result serializer:
//   WIDTH_DEF  - default width of each result word
//   NUM_RES    - number of result words in one set (NOT, AND, OR, XOR, XNOR)
//   IDX_W      - width of the operation index carried with every beat
//   OP_*       - operation index constants, in emission order
//   state_t    - serializer state type
// ---------------------------------------------------------------------------
package bitwise_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NUM_RES   = 5;
    localparam int IDX_W     = 3;

    localparam logic [IDX_W-1:0] OP_NOT  = 3'd0;
    localparam logic [IDX_W-1:0] OP_AND  = 3'd1;
    localparam logic [IDX_W-1:0] OP_OR   = 3'd2;
    localparam logic [IDX_W-1:0] OP_XOR  = 3'd3;
    localparam logic [IDX_W-1:0] OP_XNOR = 3'd4;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

endpackage

// File: rtl/bitwise_result_serializer.sv
// ---------------------------------------------------------------------------
// bitwise_result_serializer
//
// Captures one full result set (NOT, AND, OR, XOR, XNOR words) from the
// bitwise operation unit in a single valid/ready handshake, then emits the
// five words one per accepted output beat, each tagged with its operation
// index. A new set can be captured on the same cycle the last beat of the
// previous set is accepted, so full-rate streaming has no idle cycle.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   clear     - synchronous abort, drops any set in progress
//   in_valid  - upstream result set present on d0..d4
//   in_ready  - block can capture a set this cycle
//   d0..d4    - NOT, AND, OR, XOR, XNOR result words
//   out_valid - out_data/out_idx/out_last valid
//   out_ready - downstream accepts the current beat
//   out_data  - current result word
//   out_idx   - operation index 0..4
//   out_last  - high on the index-4 beat
//   busy      - a set is being held
//   out_par   - even parity of out_data (only with BITWISE_SER_PARITY_EN)
//
// Optional feature: define BITWISE_SER_PARITY_EN to add the out_par port.
// ---------------------------------------------------------------------------
module bitwise_result_serializer
    import bitwise_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
`ifdef BITWISE_SER_PARITY_EN
    ,
    output logic             out_par
`endif
);

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [WIDTH-1:0] hold_q [NUM_RES];
    logic [WIDTH-1:0] hold_d [NUM_RES];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [IDX_W-1:0] out_idx_q,   out_idx_d;
    logic             out_last_q,  out_last_d;
    logic             busy_q,      busy_d;
`ifdef BITWISE_SER_PARITY_EN
    logic             out_par_q,   out_par_d;
`endif

    logic capture;
    logic beat_done;

    // In SEND the block can only accept a new set while the final beat is
    // being handed off; clear always blocks capture.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = !clear;
            SEND:    in_ready = out_last_q && out_ready && !clear;
            default: in_ready = 1'b0;
        endcase
    end

    assign capture   = in_valid && in_ready;
    assign beat_done = out_valid_q && out_ready;

    // Next-state logic. Priority is clear, then capture (which in SEND only
    // happens on the accepted last beat), then advancing to the next word.
    // Output registers are loaded with the word they will show, so they stay
    // stable across backpressure without any extra logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;

        if (clear || (beat_done && (idx_q == OP_XNOR) && !capture)) begin
            state_d     = IDLE;
            idx_d       = OP_NOT;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = OP_NOT;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
        end else if (capture) begin
            state_d     = SEND;
            idx_d       = OP_NOT;
            hold_d[0]   = d0;
            hold_d[1]   = d1;
            hold_d[2]   = d2;
            hold_d[3]   = d3;
            hold_d[4]   = d4;
            out_valid_d = 1'b1;
            out_data_d  = d0;
            out_idx_d   = OP_NOT;
            out_last_d  = 1'b0;
            busy_d      = 1'b1;
        end else if (beat_done) begin
            idx_d       = idx_q + 3'd1;
            out_data_d  = hold_q[idx_d];
            out_idx_d   = idx_d;
            out_last_d  = (idx_d == OP_XNOR);
        end
    end

`ifdef BITWISE_SER_PARITY_EN
    // Parity follows the word loaded into out_data, so it shares its timing.
    assign out_par_d = ^out_data_d;
`endif

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= OP_NOT;
            for (int i = 0; i < NUM_RES; i++) begin
                hold_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= OP_NOT;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BITWISE_SER_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
`ifdef BITWISE_SER_PARITY_EN
            out_par_q   <= out_par_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
`ifdef BITWISE_SER_PARITY_EN
    assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_bitwise_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_bitwise_result_serializer
//
// Directed bench for bitwise_result_serializer: a cycle-by-cycle table of
// inputs and expected outputs covering a basic set, a 3-cycle stall,
// back-to-back sets and clear mid-set, followed by hand-written sequences
// for asynchronous reset mid-set and clear interactions.
// ---------------------------------------------------------------------------
module tb_bitwise_result_serializer;

    localparam int W = 4;

    // One set packed as {d0,d1,d2,d3,d4}
    localparam logic [19:0] SET_A = {4'b0101, 4'b0010, 4'b1110, 4'b1100, 4'b0011};
    localparam logic [19:0] SET_B = {4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
    localparam logic [19:0] SET_J = {4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        clr;
        logic [19:0] dset;
        logic        ev;
        logic [3:0]  edata;
        logic [2:0]  eidx;
        logic        elast;
        logic        ebusy;
        logic        erdy;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] d0, d1, d2, d3, d4;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         busy;
`ifdef BITWISE_SER_PARITY_EN
    logic         out_par;
`endif

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs [22];

    bitwise_result_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
`ifdef BITWISE_SER_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(logic iv, logic ordy, logic clr, logic [19:0] dset,
                                   logic ev, logic [3:0] edata, logic [2:0] eidx,
                                   logic elast, logic ebusy, logic erdy);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.clr = clr; v.dset = dset;
        v.ev = ev; v.edata = edata; v.eidx = eidx;
        v.elast = elast; v.ebusy = ebusy; v.erdy = erdy;
        return v;
    endfunction

    task automatic applyStimulus(input logic iv, input logic ordy, input logic clr,
                                 input logic [19:0] dset);
        in_valid  = iv;
        out_ready = ordy;
        clear     = clr;
        d0 = dset[19:16];
        d1 = dset[15:12];
        d2 = dset[11:8];
        d3 = dset[7:4];
        d4 = dset[3:0];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic checkBeat(input vec_t v, input int row);
        string tag;
        tag = $sformatf("row%0d", row);
        checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v.ev});
        checkOutput({tag, ".out_data"},  {28'd0, out_data},  {28'd0, v.edata});
        checkOutput({tag, ".out_idx"},   {29'd0, out_idx},   {29'd0, v.eidx});
        checkOutput({tag, ".out_last"},  {31'd0, out_last},  {31'd0, v.elast});
        checkOutput({tag, ".busy"},      {31'd0, busy},      {31'd0, v.ebusy});
        checkOutput({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, v.erdy});
`ifdef BITWISE_SER_PARITY_EN
        checkOutput({tag, ".out_par"},   {31'd0, out_par},   {31'd0, ^v.edata});
`endif
    endtask

    // Main sequence: inputs change on the falling edge, outputs are checked
    // 1 ns later, well away from the rising edge that updates the DUT.
    initial begin
        // Row layout: iv, ordy, clr, dset | ev, data, idx, last, busy, in_ready
        // Basic set, inputs scrambled after capture
        vecs[0]  = mkVec(1, 1, 0, SET_A, 0, 4'b0000, 0, 0, 0, 1);
        vecs[1]  = mkVec(0, 1, 0, SET_J, 1, 4'b0101, 0, 0, 1, 0);
        vecs[2]  = mkVec(0, 1, 0, SET_J, 1, 4'b0010, 1, 0, 1, 0);
        vecs[3]  = mkVec(0, 1, 0, SET_J, 1, 4'b1110, 2, 0, 1, 0);
        vecs[4]  = mkVec(0, 1, 0, SET_J, 1, 4'b1100, 3, 0, 1, 0);
        vecs[5]  = mkVec(0, 1, 0, SET_J, 1, 4'b0011, 4, 1, 1, 1);
        // Back to idle, capture again for the stall test
        vecs[6]  = mkVec(1, 1, 0, SET_A, 0, 4'b0000, 0, 0, 0, 1);
        vecs[7]  = mkVec(0, 1, 0, SET_J, 1, 4'b0101, 0, 0, 1, 0);
        vecs[8]  = mkVec(0, 1, 0, SET_J, 1, 4'b0010, 1, 0, 1, 0);
        vecs[9]  = mkVec(0, 0, 0, SET_J, 1, 4'b1110, 2, 0, 1, 0);
        vecs[10] = mkVec(0, 0, 0, SET_J, 1, 4'b1110, 2, 0, 1, 0);
        vecs[11] = mkVec(0, 0, 0, SET_J, 1, 4'b1110, 2, 0, 1, 0);
        vecs[12] = mkVec(0, 1, 0, SET_J, 1, 4'b1110, 2, 0, 1, 0);
        vecs[13] = mkVec(0, 1, 0, SET_J, 1, 4'b1100, 3, 0, 1, 0);
        // Second set offered during the last beat: zero-bubble reload
        vecs[14] = mkVec(1, 1, 0, SET_B, 1, 4'b0011, 4, 1, 1, 1);
        vecs[15] = mkVec(1, 1, 0, SET_J, 1, 4'b0000, 0, 0, 1, 0);
        vecs[16] = mkVec(0, 1, 0, SET_J, 1, 4'b0000, 1, 0, 1, 0);
        vecs[17] = mkVec(0, 1, 0, SET_J, 1, 4'b1111, 2, 0, 1, 0);
        // Clear at idx3 under backpressure
        vecs[18] = mkVec(0, 0, 1, SET_J, 1, 4'b1111, 3, 0, 1, 0);
        vecs[19] = mkVec(1, 1, 0, SET_A, 0, 4'b0000, 0, 0, 0, 1);
        vecs[20] = mkVec(0, 1, 0, SET_J, 1, 4'b0101, 0, 0, 1, 0);
        vecs[21] = mkVec(0, 1, 0, SET_J, 1, 4'b0010, 1, 0, 1, 0);

        rst = 1'b1;
        applyStimulus(0, 0, 0, 20'd0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset.out_data",  {28'd0, out_data},  32'd0);
        checkOutput("reset.out_idx",   {29'd0, out_idx},   32'd0);
        checkOutput("reset.out_last",  {31'd0, out_last},  32'd0);
        checkOutput("reset.busy",      {31'd0, busy},      32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset.in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].iv, vecs[i].ordy, vecs[i].clr, vecs[i].dset);
            #1;
            checkBeat(vecs[i], i);
        end

        // Asynchronous reset pulsed between edges while idx1 is on the output
        #1 rst = 1'b1;
        #1;
        checkOutput("arst.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("arst.out_data",  {28'd0, out_data},  32'd0);
        checkOutput("arst.out_idx",   {29'd0, out_idx},   32'd0);
        checkOutput("arst.busy",      {31'd0, busy},      32'd0);
        rst = 1'b0;
        applyStimulus(0, 1, 0, SET_J);
        #1;
        checkOutput("arst.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #1;
        checkOutput("arst.idle_valid", {31'd0, out_valid}, 32'd0);

        // Clear in IDLE blocks a simultaneous in_valid
        applyStimulus(1, 1, 1, SET_A);
        #1;
        checkOutput("clridle.in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        applyStimulus(0, 1, 0, SET_J);
        #1;
        checkOutput("clridle.out_valid", {31'd0, out_valid}, 32'd0);

        // Clear wins over an accepted beat: the set is dropped, not advanced
        applyStimulus(1, 1, 0, SET_A);
        @(negedge clk);
        applyStimulus(0, 1, 1, SET_J);
        #1;
        checkOutput("clrbeat.out_data", {28'd0, out_data}, 32'h5);
        @(negedge clk);
        applyStimulus(0, 1, 0, SET_J);
        #1;
        checkOutput("clrbeat.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("clrbeat.in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("clrbeat.out_idx",   {29'd0, out_idx},   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
